// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: op bit positions,
// FSM state encoding and cycle constants.
package md_pkg;

  localparam int OP_W = 8;

  localparam int OP_MULT  = 0;
  localparam int OP_MULTU = 1;
  localparam int OP_DIV   = 2;
  localparam int OP_DIVU  = 3;
  localparam int OP_MFHI  = 4;
  localparam int OP_MFLO  = 5;
  localparam int OP_MTHI  = 6;
  localparam int OP_MTLO  = 7;

  localparam int DIV_STEPS  = 32;
  localparam int DIV_CYCLES = DIV_STEPS + 1;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV
  } md_state_e;

endpackage

// File: rtl/md_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes,
// sign correction applied combinationally once all steps are done.
module md_div_iter
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        kill,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rem_q, rem_d;
  logic [31:0]      quo_q, quo_d;
  logic [31:0]      dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [32:0]      trial;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    trial     = {rem_q, quo_q[31]} - {1'b0, dvs_q};

    if (kill) begin
      busy_d = 1'b0;
    end else if (start) begin
      busy_d    = 1'b1;
      cnt_d     = '0;
      rem_d     = '0;
      quo_d     = (is_signed && dividend[31]) ? -dividend : dividend;
      dvs_d     = (is_signed && divisor[31])  ? -divisor  : divisor;
      neg_quo_d = is_signed & (dividend[31] ^ divisor[31]);
      neg_rem_d = is_signed & dividend[31];
    end else if (busy_q) begin
      if (cnt_q != CNT_W'(DIV_STEPS)) begin
        // A set borrow bit means the trial subtraction went negative: restore.
        rem_d = trial[32] ? {rem_q[30:0], quo_q[31]} : trial[31:0];
        quo_d = {quo_q[30:0], ~trial[32]};
        cnt_d = cnt_q + 1'b1;
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  assign done      = busy_q && (cnt_q == CNT_W'(DIV_STEPS));
  assign quotient  = neg_quo_q ? -quo_q : quo_q;
  assign remainder = neg_rem_q ? -rem_q : rem_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // NOTE: datapath registers are not reset; busy_q guards every use of them.
  always_ff @(posedge clk) begin
    rem_q     <= rem_d;
    quo_q     <= quo_d;
    dvs_q     <= dvs_d;
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
  end

endmodule

// File: rtl/md_ctrl.sv
// HI/LO owner beside EXE: sequences MULT/MULTU over a fixed window and
// DIV/DIVU through md_div_iter, back-pressuring EXE while busy.
module md_ctrl
  import md_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            md_valid_in,
  input  logic [OP_W-1:0] md_op_in,
  input  logic [31:0]     md_src1_in,
  input  logic [31:0]     md_src2_in,
  input  logic            flush_in,
  output logic            md_allowin_out,
  output logic            md_busy_out,
  output logic [31:0]     md_rdata_out,
  output logic            md_done_out,
  output logic [31:0]     hi_out,
  output logic [31:0]     lo_out
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      src1_q, src1_d, src2_q, src2_d;
  logic             mul_signed_q, mul_signed_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             transfer, div_start, div_done;
  logic [31:0]      div_quo, div_rem;
  logic [63:0]      mul_a, mul_b, prod;

  assign md_allowin_out = (state_q == ST_IDLE);
  assign transfer  = md_valid_in & md_allowin_out & (|md_op_in) & ~flush_in;
  assign div_start = transfer & (md_op_in[OP_DIV] | md_op_in[OP_DIVU]);

  // Sign-extending to 64 bits makes the low 64 product bits right for both forms.
  assign mul_a = {{32{mul_signed_q & src1_q[31]}}, src1_q};
  assign mul_b = {{32{mul_signed_q & src2_q[31]}}, src2_q};
  assign prod  = mul_a * mul_b;

  md_div_iter u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .kill      (flush_in),
    .dividend  (md_src1_in),
    .divisor   (md_src2_in),
    .is_signed (md_op_in[OP_DIV]),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    src1_d       = src1_q;
    src2_d       = src2_q;
    mul_signed_d = mul_signed_q;
    done_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          if (md_op_in[OP_MULT] || md_op_in[OP_MULTU]) begin
            src1_d       = md_src1_in;
            src2_d       = md_src2_in;
            mul_signed_d = md_op_in[OP_MULT];
            cnt_d        = CNT_W'(MUL_CYCLES - 1);
            state_d      = ST_MUL;
          end else if (div_start) begin
            cnt_d   = CNT_W'(DIV_STEPS);
            state_d = ST_DIV;
          end
          if (md_op_in[OP_MTHI]) hi_d = md_src1_in;
          if (md_op_in[OP_MTLO]) lo_d = md_src1_in;
        end
      end
      ST_MUL: begin
        if (flush_in) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DIV: begin
        if (flush_in) begin
          state_d = ST_IDLE;
        end else if (div_done) begin
          hi_d    = div_rem;
          lo_d    = div_quo;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_comb begin
    md_rdata_out = '0;
    if (md_valid_in && state_q == ST_IDLE) begin
      if (md_op_in[OP_MFHI])      md_rdata_out = hi_q;
      else if (md_op_in[OP_MFLO]) md_rdata_out = lo_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    src1_q       <= src1_d;
    src2_q       <= src2_d;
    mul_signed_q <= mul_signed_d;
  end

  assign md_busy_out = busy_q;
  assign md_done_out = done_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Scoreboard bench for md_ctrl: the driver pushes expected HI/LO and MF read
// data from an arithmetic model; a negedge monitor pops and compares.
module tb_md_ctrl;
  import md_pkg::*;

  localparam int MUL_CYCLES = 2;
  localparam int BOUND      = 100;

  logic            clk = 1'b0;
  logic            rst;
  logic            md_valid_in;
  logic [OP_W-1:0] md_op_in;
  logic [31:0]     md_src1_in, md_src2_in;
  logic            flush_in;
  logic            md_allowin_out, md_busy_out, md_done_out;
  logic [31:0]     md_rdata_out, hi_out, lo_out;

  md_ctrl #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk            (clk),
    .rst            (rst),
    .md_valid_in    (md_valid_in),
    .md_op_in       (md_op_in),
    .md_src1_in     (md_src1_in),
    .md_src2_in     (md_src2_in),
    .flush_in       (flush_in),
    .md_allowin_out (md_allowin_out),
    .md_busy_out    (md_busy_out),
    .md_rdata_out   (md_rdata_out),
    .md_done_out    (md_done_out),
    .hi_out         (hi_out),
    .lo_out         (lo_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rd_q[$];
  exp_t        mon_e;
  logic [31:0] mon_r;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] hi_m, lo_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: completions and MF reads are checked whenever the DUT presents them.
  always @(negedge clk) begin
    if (!rst) begin
      if (md_done_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(md_done_out), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check({mon_e.name, "_hi"}, 64'(hi_out), 64'(mon_e.hi));
          check({mon_e.name, "_lo"}, 64'(lo_out), 64'(mon_e.lo));
        end
      end
      if (md_valid_in && (md_op_in[OP_MFHI] || md_op_in[OP_MFLO])) begin
        if (md_allowin_out) begin
          if (rd_q.size() == 0) begin
            check("unexpected_read", 64'(md_valid_in), 64'd0);
          end else begin
            mon_r = rd_q.pop_front();
            check("mf_rdata", 64'(md_rdata_out), 64'(mon_r));
          end
        end else begin
          check("mf_rdata_while_busy", 64'(md_rdata_out), 64'd0);
        end
      end
    end
  end

  // Reference model: architectural HI/LO after every issued op completes.
  task automatic ref_op(input int op, input logic [31:0] a, input logic [31:0] b);
    longint      ps;
    logic [63:0] pu;
    int          sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (op)
      OP_MULT: begin
        ps = longint'(sa) * longint'(sb);
        hi_m = ps[63:32];
        lo_m = ps[31:0];
      end
      OP_MULTU: begin
        pu = 64'(a) * 64'(b);
        hi_m = pu[63:32];
        lo_m = pu[31:0];
      end
      OP_DIV: begin
        if (b == 32'd0) begin
          hi_m = a;
          lo_m = (sa < 0) ? 32'd1 : 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          hi_m = 32'd0;
          lo_m = 32'h8000_0000;
        end else begin
          lo_m = 32'(sa / sb);
          hi_m = 32'(sa % sb);
        end
      end
      OP_DIVU: begin
        if (b == 32'd0) begin
          hi_m = a;
          lo_m = 32'hFFFF_FFFF;
        end else begin
          lo_m = a / b;
          hi_m = a % b;
        end
      end
      OP_MTHI: hi_m = a;
      OP_MTLO: lo_m = a;
      OP_MFHI: rd_q.push_back(hi_m);
      OP_MFLO: rd_q.push_back(lo_m);
      default: ;
    endcase
    if (op <= OP_DIVU) exp_q.push_back('{hi: hi_m, lo: lo_m, name: $sformatf("op%0d", op)});
  endtask

  // All driving happens 1 time unit after the rising edge.
  task automatic wait_idle();
    int n = 0;
    while (!md_allowin_out && n < BOUND) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= BOUND) check("idle_timeout", 64'(md_allowin_out), 64'd1);
  endtask

  task automatic drive(input int op, input logic [31:0] a, input logic [31:0] b, input logic fl);
    md_valid_in = 1'b1;
    md_op_in    = OP_W'(1 << op);
    md_src1_in  = a;
    md_src2_in  = b;
    flush_in    = fl;
    @(posedge clk); #1;
    md_valid_in = 1'b0;
    md_op_in    = '0;
    flush_in    = 1'b0;
    md_src1_in  = $urandom;
    md_src2_in  = $urandom;
  endtask

  task automatic count_busy(input int want, input string name);
    int n = 0;
    check({name, "_busy"}, 64'(md_busy_out), 64'd1);
    while (!md_allowin_out && n < BOUND) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_stall_cycles"}, 64'(n), 64'(want));
    check({name, "_done_pulse"}, 64'(md_done_out), 64'd1);
  endtask

  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b);
    wait_idle();
    ref_op(op, a, b);
    drive(op, a, b, 1'b0);
    if (op == OP_MTHI || op == OP_MTLO) begin
      check("mt_hi", 64'(hi_out), 64'(hi_m));
      check("mt_lo", 64'(lo_out), 64'(lo_m));
    end else if (op == OP_MULT || op == OP_MULTU) begin
      count_busy(MUL_CYCLES, "mul");
    end else if (op == OP_DIV || op == OP_DIVU) begin
      count_busy(DIV_CYCLES, "div");
    end
  endtask

  // Start an op, flush at cycle t+k (k>=1), then expect idle with HI/LO unchanged.
  task automatic flush_at(input int op, input int k, input string name);
    wait_idle();
    drive(op, $urandom, $urandom_range(1, 1000), 1'b0);
    repeat (k - 1) begin
      @(posedge clk); #1;
    end
    flush_in = 1'b1;
    @(posedge clk); #1;
    flush_in = 1'b0;
    check({name, "_allowin"}, 64'(md_allowin_out), 64'd1);
    check({name, "_busy"}, 64'(md_busy_out), 64'd0);
    check({name, "_no_done"}, 64'(md_done_out), 64'd0);
    check({name, "_hi_kept"}, 64'(hi_out), 64'(hi_m));
    check({name, "_lo_kept"}, 64'(lo_out), 64'(lo_m));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 50));
      5: return -32'($urandom_range(1, 50));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    md_valid_in = 1'b0;
    md_op_in = '0;
    md_src1_in = '0;
    md_src2_in = '0;
    flush_in = 1'b0;
    hi_m = '0;
    lo_m = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_allowin", 64'(md_allowin_out), 64'd1);
    check("rst_busy", 64'(md_busy_out), 64'd0);
    check("rst_done", 64'(md_done_out), 64'd0);
    check("rst_rdata", 64'(md_rdata_out), 64'd0);
    check("rst_hi", 64'(hi_out), 64'd0);
    check("rst_lo", 64'(lo_out), 64'd0);

    // Back-to-back MTHI then MFHI.
    run_op(OP_MTHI, 32'h1234_5678, 32'd0);
    run_op(OP_MFHI, 32'd0, 32'd0);
    check("hi_after_mfhi", 64'(hi_out), 64'h1234_5678);

    run_op(OP_MULT,  32'hFFFF_FFFF, 32'd2);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    run_op(OP_DIV,   -32'd7, 32'd2);
    run_op(OP_DIVU,  32'd100, 32'd7);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    run_op(OP_DIVU,  32'd5, 32'd0);
    run_op(OP_DIV,   -32'd9, 32'd0);
    run_op(OP_DIV,   32'd9, 32'd0);
    run_op(OP_MTLO,  32'hCAFE_0001, 32'd0);
    run_op(OP_MFLO,  32'd0, 32'd0);

    flush_at(OP_DIV, 10, "flush_div_mid");
    flush_at(OP_DIVU, DIV_CYCLES, "flush_div_last");
    flush_at(OP_MULT, MUL_CYCLES, "flush_mul_last");

    // Flush coinciding with a transfer drops the op.
    wait_idle();
    drive(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b1);
    check("flush_mthi_hi_kept", 64'(hi_out), 64'(hi_m));

    // MFLO held across a DIV: blocked until idle, then returns the new LO.
    wait_idle();
    ref_op(OP_DIV, 32'd1000, -32'd3);
    drive(OP_DIV, 32'd1000, -32'd3, 1'b0);
    md_valid_in = 1'b1;
    md_op_in = OP_W'(1 << OP_MFLO);
    rd_q.push_back(lo_m);
    count_busy(DIV_CYCLES, "div_mflo_hold");
    @(posedge clk); #1;
    md_valid_in = 1'b0;
    md_op_in = '0;

    // Reset in the middle of a multiply.
    wait_idle();
    drive(OP_MULTU, 32'd77, 32'd88, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_hi", 64'(hi_out), 64'd0);
    check("midrst_lo", 64'(lo_out), 64'd0);
    check("midrst_allowin", 64'(md_allowin_out), 64'd1);
    @(posedge clk); #1;
    check("midrst_busy", 64'(md_busy_out), 64'd0);
    rst = 1'b0;
    hi_m = '0;
    lo_m = '0;

    for (int i = 0; i < 60; i++) begin
      run_op(int'($urandom_range(0, OP_W - 1)), pick(), pick());
    end

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("reads_drained", 64'(rd_q.size()), 64'd0);
    check("final_hi", 64'(hi_out), 64'(hi_m));
    check("final_lo", 64'(lo_out), 64'(lo_m));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
